// File: rtl/text_pixel_engine_pkg.sv
// Shared types and constants for the character-mode pixel engine.
// Optional attribute blink is enabled by defining TEXT_BLINK_EN.
package text_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_CHAR,
      RD_ATTR,
      RD_FONT,
      DONE
   } fetch_state_t;

   localparam int FG_LSB    = 0;
   localparam int BG_LSB    = 4;
   localparam int BLINK_BIT = 7;
   localparam int GLYPH_W   = 8;

   typedef struct packed {
      logic               hsync;
      logic               vsync;
      logic               de;
      logic               cursor;
      logic [7:0]         attr;
      logic [GLYPH_W-1:0] glyph;
   } cell_t;

endpackage

// File: rtl/text_pixel_engine_fetch_seq.sv
// Per-character fetch sequencer: VRAM char/attr reads, font ROM read and
// capture of the fetched cell (stage A) together with its CRTC sideband.
module text_fetch_seq
   import text_pkg::*;
#(
   parameter int VRAM_AW = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               divclk,
   input  logic [13:0]        mem_addr,
   input  logic [4:0]         row_addr,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               display_enable,
   input  logic               cursor,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic               vram_rd,
   input  logic [7:0]         vram_data,
   output logic [11:0]        font_addr,
   output logic               font_rd,
   input  logic [7:0]         font_data,
   output cell_t              cell_a
);

   fetch_state_t       state_q, state_d;
   logic [13:0]        ma_q, ma_d;
   logic [3:0]         row_q, row_d;
   cell_t              cell_q, cell_d;
   logic               fpend_q, fpend_d;
   logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
   logic               vram_rd_q, vram_rd_d;
   logic [11:0]        font_addr_q, font_addr_d;
   logic               font_rd_q, font_rd_d;
   logic               unused_row_msb;

   assign unused_row_msb = row_addr[4];

   // Glyph data trails font_rd by one clk, so it is captured whenever the
   // previous cycle strobed the ROM; a divclk always restarts the fetch.
   always_comb begin
      state_d     = state_q;
      ma_d        = ma_q;
      row_d       = row_q;
      cell_d      = cell_q;
      fpend_d     = font_rd_q;
      vram_addr_d = vram_addr_q;
      vram_rd_d   = 1'b0;
      font_addr_d = font_addr_q;
      font_rd_d   = 1'b0;
      if (fpend_q)
         cell_d.glyph = font_data;
      if (divclk) begin
         ma_d          = mem_addr;
         row_d         = row_addr[3:0];
         cell_d.hsync  = hsync;
         cell_d.vsync  = vsync;
         cell_d.de     = display_enable;
         cell_d.cursor = cursor;
         vram_addr_d   = VRAM_AW'({mem_addr, 1'b0});
         vram_rd_d     = 1'b1;
         state_d       = RD_CHAR;
      end else begin
         case (state_q)
            RD_CHAR: begin
               vram_addr_d = VRAM_AW'({ma_q, 1'b1});
               vram_rd_d   = 1'b1;
               state_d     = RD_ATTR;
            end
            RD_ATTR: begin
               font_addr_d = {vram_data, row_q};
               font_rd_d   = 1'b1;
               state_d     = RD_FONT;
            end
            RD_FONT: begin
               cell_d.attr = vram_data;
               state_d     = DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         ma_q        <= '0;
         row_q       <= '0;
         cell_q      <= '0;
         fpend_q     <= 1'b0;
         vram_addr_q <= '0;
         vram_rd_q   <= 1'b0;
         font_addr_q <= '0;
         font_rd_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ma_q        <= ma_d;
         row_q       <= row_d;
         cell_q      <= cell_d;
         fpend_q     <= fpend_d;
         vram_addr_q <= vram_addr_d;
         vram_rd_q   <= vram_rd_d;
         font_addr_q <= font_addr_d;
         font_rd_q   <= font_rd_d;
      end
   end

   // An incomplete fetch hands over a blank glyph; a glyph still on the
   // font bus is forwarded so short character periods lose nothing.
   always_comb begin
      cell_a = cell_q;
      if (state_q != DONE)
         cell_a.glyph = '0;
      else if (fpend_q)
         cell_a.glyph = font_data;
   end

   assign vram_addr = vram_addr_q;
   assign vram_rd   = vram_rd_q;
   assign font_addr = font_addr_q;
   assign font_rd   = font_rd_q;

endmodule

// File: rtl/text_pixel_engine.sv
// Character-mode pixel generator: fetch sequencer, display stage, glyph
// serializer and IRGB colour mux. Define TEXT_BLINK_EN for attribute blink.
module text_pixel_engine
   import text_pkg::*;
#(
   parameter int CHAR_W  = 8,
   parameter int VRAM_AW = 15
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               divclk,
   input  logic [13:0]        mem_addr,
   input  logic [4:0]         row_addr,
   input  logic               hsync,
   input  logic               vsync,
   input  logic               display_enable,
   input  logic               cursor,
   input  logic               blink_mode,
   input  logic [3:0]         border_color,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic               vram_rd,
   input  logic [7:0]         vram_data,
   output logic [11:0]        font_addr,
   output logic               font_rd,
   input  logic [7:0]         font_data,
   output logic [3:0]         pixel,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic               de_out
);

   cell_t              cell_a, cell_b_q, cell_b_d;
   logic [GLYPH_W-1:0] shift_q, shift_d;
   logic [3:0]         pixel_q, pixel_d;
   logic               hsync_out_q, vsync_out_q, de_out_q;
   logic [3:0]         fg, bg;
   logic               blink_on;
   logic [7:0]         unused_cfg;

   assign unused_cfg = 8'(CHAR_W);

   text_fetch_seq #(.VRAM_AW(VRAM_AW)) u_fetch (
      .clk            (clk),
      .reset_n        (reset_n),
      .divclk         (divclk),
      .mem_addr       (mem_addr),
      .row_addr       (row_addr),
      .hsync          (hsync),
      .vsync          (vsync),
      .display_enable (display_enable),
      .cursor         (cursor),
      .vram_addr      (vram_addr),
      .vram_rd        (vram_rd),
      .vram_data      (vram_data),
      .font_addr      (font_addr),
      .font_rd        (font_rd),
      .font_data      (font_data),
      .cell_a         (cell_a)
   );

`ifdef TEXT_BLINK_EN
   logic [4:0] blink_cnt_q, blink_cnt_d;
   logic       vsync_prev_q;

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      if (vsync && !vsync_prev_q)
         blink_cnt_d = blink_cnt_q + 5'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blink_cnt_q  <= '0;
         vsync_prev_q <= 1'b0;
      end else begin
         blink_cnt_q  <= blink_cnt_d;
         vsync_prev_q <= vsync;
      end
   end

   assign bg       = blink_mode ? {1'b0, cell_b_q.attr[BG_LSB +: 3]} : cell_b_q.attr[BG_LSB +: 4];
   assign blink_on = blink_mode & cell_b_q.attr[BLINK_BIT] & blink_cnt_q[4];
`else
   logic unused_blink_mode;

   assign unused_blink_mode = blink_mode;
   assign bg                = cell_b_q.attr[BG_LSB +: 4];
   assign blink_on          = 1'b0;
`endif

   assign fg = blink_on ? bg : cell_b_q.attr[FG_LSB +: 4];

   // Pixel and sideband are registered from stage B so both change on the
   // same clk as the first serialized column of a cell.
   always_comb begin
      cell_b_d = cell_b_q;
      shift_d  = shift_q << 1;
      if (divclk) begin
         cell_b_d = cell_a;
         shift_d  = cell_a.glyph;
      end
      if (!cell_b_q.de)
         pixel_d = border_color;
      else if (cell_b_q.cursor)
         pixel_d = cell_b_q.attr[FG_LSB +: 4];
      else
         pixel_d = shift_q[GLYPH_W-1] ? fg : bg;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cell_b_q    <= '0;
         shift_q     <= '0;
         pixel_q     <= '0;
         hsync_out_q <= 1'b0;
         vsync_out_q <= 1'b0;
         de_out_q    <= 1'b0;
      end else begin
         cell_b_q    <= cell_b_d;
         shift_q     <= shift_d;
         pixel_q     <= pixel_d;
         hsync_out_q <= cell_b_q.hsync;
         vsync_out_q <= cell_b_q.vsync;
         de_out_q    <= cell_b_q.de;
      end
   end

   assign pixel     = pixel_q;
   assign hsync_out = hsync_out_q;
   assign vsync_out = vsync_out_q;
   assign de_out    = de_out_q;

endmodule

// File: tb/tb_text_pixel_engine.sv
// Directed self-checking bench for text_pixel_engine with VRAM and font ROM
// models; blink cases are selected by TEXT_BLINK_EN.
module tb_text_pixel_engine;

   localparam int CHAR_W  = 8;
   localparam int VRAM_AW = 15;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               divclk;
   logic [13:0]        mem_addr;
   logic [4:0]         row_addr;
   logic               hsync, vsync, display_enable, cursor, blink_mode;
   logic [3:0]         border_color;
   logic [VRAM_AW-1:0] vram_addr;
   logic               vram_rd;
   logic [7:0]         vram_data;
   logic [11:0]        font_addr;
   logic               font_rd;
   logic [7:0]         font_data;
   logic [3:0]         pixel;
   logic               hsync_out, vsync_out, de_out;

   logic [7:0] vram_mem [0:32767];
   logic [7:0] font_rom [0:4095];

   int check_count = 0;
   int error_count = 0;

   text_pixel_engine #(.CHAR_W(CHAR_W), .VRAM_AW(VRAM_AW)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .divclk         (divclk),
      .mem_addr       (mem_addr),
      .row_addr       (row_addr),
      .hsync          (hsync),
      .vsync          (vsync),
      .display_enable (display_enable),
      .cursor         (cursor),
      .blink_mode     (blink_mode),
      .border_color   (border_color),
      .vram_addr      (vram_addr),
      .vram_rd        (vram_rd),
      .vram_data      (vram_data),
      .font_addr      (font_addr),
      .font_rd        (font_rd),
      .font_data      (font_data),
      .pixel          (pixel),
      .hsync_out      (hsync_out),
      .vsync_out      (vsync_out),
      .de_out         (de_out)
   );

   always #5 clk = ~clk;

   // Memories answer one clk after their read strobe.
   always @(posedge clk) begin
      if (vram_rd)
         vram_data <= vram_mem[vram_addr];
      if (font_rd)
         font_data <= font_rom[font_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      check_count++;
      if (got !== exp) begin
         error_count++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [13:0] ma, input logic [4:0] row, input logic [7:0] ch,
                                input logic [7:0] attr, input logic [7:0] glyph,
                                input logic de, input logic cur, input logic hs);
      vram_mem[{ma, 1'b0}]    = ch;
      vram_mem[{ma, 1'b1}]    = attr;
      font_rom[{ch, row[3:0]}] = glyph;
      mem_addr       = ma;
      row_addr       = row;
      display_enable = de;
      cursor         = cur;
      hsync          = hs;
   endtask

   // Called at a negedge: divclk sampled at edge T, strobes checked in
   // cycles T..T+3, second divclk at T+8, pixels checked from T+9.
   task automatic runCell(input string tag, input logic [13:0] ma, input logic [7:0] ch,
                          input logic [4:0] row, input logic [31:0] exp_pix,
                          input logic exp_de, input logic exp_hs);
      divclk = 1'b1;
      @(negedge clk);
      divclk = 1'b0;
      for (int c = 0; c < 8; c++) begin
         case (c)
            0: begin
               checkOutput({tag, "_rd0"}, 32'(vram_rd), 32'd1);
               checkOutput({tag, "_addr0"}, 32'(vram_addr), 32'({ma, 1'b0}));
            end
            1: begin
               checkOutput({tag, "_rd1"}, 32'(vram_rd), 32'd1);
               checkOutput({tag, "_addr1"}, 32'(vram_addr), 32'({ma, 1'b1}));
            end
            2: begin
               checkOutput({tag, "_rd2"}, 32'(vram_rd), 32'd0);
               checkOutput({tag, "_frd"}, 32'(font_rd), 32'd1);
               checkOutput({tag, "_faddr"}, 32'(font_addr), 32'({ch, row[3:0]}));
            end
            3: checkOutput({tag, "_frd3"}, 32'(font_rd), 32'd0);
            default: ;
         endcase
         if (c == 7)
            divclk = 1'b1;
         @(negedge clk);
      end
      divclk = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         checkOutput($sformatf("%s_px%0d", tag, i), 32'(pixel), 32'(exp_pix[31-4*i -: 4]));
         if (i == 0) begin
            checkOutput({tag, "_de"}, 32'(de_out), 32'(exp_de));
            checkOutput({tag, "_hs"}, 32'(hsync_out), 32'(exp_hs));
         end
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int a = 0; a < 32768; a++) vram_mem[a] = 8'h00;
      for (int a = 0; a < 4096; a++)  font_rom[a] = 8'h00;
      vram_data      = 8'h00;
      font_data      = 8'h00;
      reset_n        = 1'b0;
      divclk         = 1'b0;
      mem_addr       = '0;
      row_addr       = '0;
      hsync          = 1'b0;
      vsync          = 1'b0;
      display_enable = 1'b0;
      cursor         = 1'b0;
      blink_mode     = 1'b0;
      border_color   = 4'h0;

      repeat (3) @(negedge clk);
      checkOutput("rst_pixel", 32'(pixel), 32'd0);
      checkOutput("rst_vram_rd", 32'(vram_rd), 32'd0);
      checkOutput("rst_font_rd", 32'(font_rd), 32'd0);
      checkOutput("rst_vram_addr", 32'(vram_addr), 32'd0);
      checkOutput("rst_font_addr", 32'(font_addr), 32'd0);
      checkOutput("rst_de_out", 32'(de_out), 32'd0);
      checkOutput("rst_hs_out", 32'(hsync_out), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Basic cell: fg E, bg 1, glyph C3.
      applyStimulus(14'h0000, 5'd3, 8'h41, 8'h1E, 8'hC3, 1'b1, 1'b0, 1'b0);
      runCell("basic", 14'h0000, 8'h41, 5'd3, 32'hEE1111EE, 1'b1, 1'b0);

      // Intensity background: bg 8, fg F.
      applyStimulus(14'h0010, 5'd5, 8'h62, 8'h8F, 8'h0F, 1'b1, 1'b0, 1'b0);
      runCell("bgint", 14'h0010, 8'h62, 5'd5, 32'h8888FFFF, 1'b1, 1'b0);

      // Cursor overrides a blank glyph; hsync travels with the cell.
      applyStimulus(14'h0123, 5'd1, 8'h20, 8'h07, 8'h00, 1'b1, 1'b1, 1'b1);
      runCell("cursor", 14'h0123, 8'h20, 5'd1, 32'h77777777, 1'b1, 1'b1);

      // Outside the display area the border colour is shown.
      border_color = 4'h3;
      applyStimulus(14'h0200, 5'd2, 8'h33, 8'h1E, 8'hFF, 1'b0, 1'b0, 1'b0);
      runCell("border", 14'h0200, 8'h33, 5'd2, 32'h33333333, 1'b0, 1'b0);
      border_color = 4'h0;

`ifdef TEXT_BLINK_EN
      blink_mode = 1'b1;
      applyStimulus(14'h0300, 5'd4, 8'h44, 8'h8F, 8'hFF, 1'b1, 1'b0, 1'b0);
      runCell("blink_off", 14'h0300, 8'h44, 5'd4, 32'hFFFFFFFF, 1'b1, 1'b0);
      repeat (16) begin
         vsync = 1'b1;
         @(negedge clk);
         vsync = 1'b0;
         @(negedge clk);
      end
      runCell("blink_on", 14'h0300, 8'h44, 5'd4, 32'h00000000, 1'b1, 1'b0);
      applyStimulus(14'h0310, 5'd6, 8'h55, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0);
      runCell("bg_bm1", 14'h0310, 8'h55, 5'd6, 32'h44444444, 1'b1, 1'b0);
      blink_mode = 1'b0;
      runCell("bg_bm0", 14'h0310, 8'h55, 5'd6, 32'hCCCCCCCC, 1'b1, 1'b0);
`else
      applyStimulus(14'h0310, 5'd6, 8'h55, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0);
      blink_mode = 1'b1;
      runCell("nob_bm1", 14'h0310, 8'h55, 5'd6, 32'hCCCCCCCC, 1'b1, 1'b0);
      blink_mode = 1'b0;
      runCell("nob_bm0", 14'h0310, 8'h55, 5'd6, 32'hCCCCCCCC, 1'b1, 1'b0);
`endif

      // Reset one clk into a fetch, then a clean fetch after release.
      border_color = 4'h5;
      applyStimulus(14'h0400, 5'd0, 8'h11, 8'h1E, 8'hFF, 1'b1, 1'b0, 1'b0);
      divclk = 1'b1;
      @(negedge clk);
      divclk  = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_vram_rd", 32'(vram_rd), 32'd0);
      checkOutput("midrst_pixel", 32'(pixel), 32'd0);
      checkOutput("midrst_font_rd", 32'(font_rd), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      border_color = 4'h0;
      applyStimulus(14'h0005, 5'd7, 8'h52, 8'h2A, 8'hA5, 1'b1, 1'b0, 1'b0);
      runCell("postrst", 14'h0005, 8'h52, 5'd7, 32'hA2A22A2A, 1'b1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
      $finish;
   end

endmodule

// File: doc/text_pixel_engine.md
# text_pixel_engine

Character-mode pixel generator that sits downstream of the CRTC timing block. It consumes the CRTC's per-character memory address, row address, sync, display-enable and cursor outputs, and fetches the character code and attribute from VRAM and the glyph row from the font ROM. It then serializes the glyph into one 4-bit IRGB pixel per clock, with sync and blanking realigned to the pixel stream.

## Interface
Parameters:
- CHAR_W, 8: pixel clocks per character period (divclk spacing); legal range 4..8.
- VRAM_AW, 15: VRAM byte-address width.

Ports:
- clk  in  1  pixel clock
- reset_n  in  1  synchronous, active-low reset
- divclk  in  1  character-clock enable from CRTC, one clk high every CHAR_W clks
- mem_addr  in  14  CRTC character address
- row_addr  in  5  CRTC scanline within row
- hsync, vsync, display_enable, cursor  in  1 each  CRTC timing outputs
- blink_mode  in  1  1: attr[7] = blink, 0: attr[7] = background intensity
- border_color  in  4  IRGB colour driven outside the display area
- vram_addr  out  VRAM_AW  byte address
- vram_rd  out  1  read strobe
- vram_data  in  8  read data, valid exactly 1 clk after vram_rd
- font_addr  out  12  {char[7:0], row_addr[3:0]}
- font_rd  out  1  read strobe
- font_data  in  8  glyph row, MSB = leftmost pixel, valid 1 clk after font_rd
- pixel  out  4  IRGB
- hsync_out, vsync_out, de_out  out  1 each  delayed sideband

## Operation
- Fetch FSM states: IDLE, RD_CHAR, RD_ATTR, RD_FONT, DONE.
- IDLE/DONE + divclk (cycle T):
  - latch ma = mem_addr, row = row_addr, plus hsync/vsync/display_enable/cursor into stage A;
  - vram_addr = {ma,1'b0}, vram_rd = 1;
  - go to RD_CHAR.
- RD_CHAR (T+1): capture char = vram_data; vram_addr = {ma,1'b1}, vram_rd = 1; go to RD_ATTR.
- RD_ATTR (T+2): capture attr; font_addr = {char,row[3:0]}, font_rd = 1; go to RD_FONT.
- RD_FONT (T+3): capture glyph; go to DONE.
- divclk in any non-IDLE/DONE state (only after misconfiguration or reset release): abandon the fetch and restart from the new address. Stage B for that character loads a glyph of 8'h00.
- Next divclk (T+CHAR_W):
  - stage A (glyph, attr, sideband) transfers to stage B;
  - shift register loads glyph;
  - a new fetch starts.
- Shift register shifts left one bit per clk. Columns beyond 8 are unreachable (CHAR_W ≤ 8).
- Colour rules:
  - fg = attr[3:0].
  - bg = {attr[7],attr[6:4]} when blink_mode = 0; {1'b0,attr[6:4]} when blink_mode = 1.
  - Blink: blink_mode = 1, attr[7] = 1 and blink_cnt[4] = 1 → fg replaced by bg.
  - Cursor asserted in stage B → every pixel of the cell = attr[3:0], overriding glyph and blink.
  - de_B = 0 → pixel = border_color.
- blink_cnt: 5-bit counter, increments on each rising edge of vsync; wraps 31→0.

## Timing
- Pipeline: character sampled at divclk cycle T.
  - Its first pixel appears on pixel at T+CHAR_W+1 and lasts CHAR_W clks.
  - hsync_out/vsync_out/de_out change on the same clk as that first pixel.
- VRAM/font strobes are single-cycle pulses. No back-pressure; read latency is fixed at 1.
- Reset values:
  - pixel = 0; hsync_out = vsync_out = de_out = 0;
  - vram_rd = font_rd = 0; vram_addr = font_addr = 0;
  - FSM = IDLE; blink_cnt = 0; shift register = 0; stages A/B cleared.
- Reset mid-fetch: the in-flight fetch is dropped, outputs return to reset values on the next clk, and the first divclk after release starts a clean fetch.
- Widths: vram_addr is {ma,bit0} truncated to VRAM_AW; upper ma bits beyond VRAM_AW-1 are discarded (wrap).

## Configuration
- TEXT_BLINK_EN defined: blink_mode, blink_cnt and the attribute blink path are implemented as above.
- Undefined: blink_cnt is removed, blink_mode is ignored, and attr[7] is always background intensity (bg = attr[7:4]).
- The cursor override is present in both builds.

## Structure
- Package text_pkg holds:
  - fetch state enum;
  - attribute field constants (FG_LSB = 0, BG_LSB = 4, BLINK_BIT = 7);
  - glyph width constant 8.
- Sub-module text_fetch_seq contains the fetch FSM, VRAM/font strobes and stage-A capture.
- The top level contains stage B, the shift register, colour mux and blink counter.

## Test plan
- VRAM[0] = 8'h41, VRAM[1] = 8'h1E, glyph row = 8'b1100_0011, CHAR_W = 8, divclk at T: pixel from T+9 = E,E,1,1,1,1,E,E; vram_rd pulses at T and T+1 (addr 0, 1); font_addr = 12'h41r at T+2.
- attr = 8'h8F, blink_mode = 1, glyph = 8'hFF: pixel = F for blink_cnt < 16 and 0 after 16 vsync rising edges; with blink_mode = 0, bg = 8 and fg = F.
- cursor = 1 with glyph = 8'h00, attr = 8'h07: all 8 pixels = 7.
- display_enable = 0, border_color = 4'h3: pixel = 3 for the cell; de_out = 0 aligned with it.
- reset_n low at T+1 mid-fetch: vram_rd = 0 and pixel = 0 next clk; first divclk after release fetches correctly, with the first pixel CHAR_W+1 clks later.
- Without TEXT_BLINK_EN: attr = 8'hC0, glyph = 8'h00 gives pixel = C regardless of blink_mode.
